mem_port_arbiter: RTL

- Shares the single 16-bit/24-bit-address memory port between the CPU core and the I/O engine (IR/servo peripheral block).
- Each requester issues single-word read or write accesses over a req/gnt handshake.
- The arbiter muxes address, write-data and write-enable onto the memory, and routes read data back with a valid strobe.
- It sits between the core, the I/O engine and the memory.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory port: core and I/O engine, zero-latency grant.
// Default build is core-priority with a MAX_BURST starvation guard; define ARB_ROUND_ROBIN_EN
// to alternate between requesters on contention instead.
module mem_port_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    IO   = 2'd2
  } state_e;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_e              state_q, state_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  // rd_pend is stored as "last access was a read"; its owner is state_q.
  logic                rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]   io_rdata_q, io_rdata_d;
  logic                io_wins;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    core_gnt    = 1'b0;
    io_gnt      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    state_d     = IDLE;
    rd_pend_d   = 1'b0;
    burst_cnt_d = burst_cnt_q;

`ifdef ARB_ROUND_ROBIN_EN
    io_wins = (state_q != IO);
`else
    io_wins = (burst_cnt_q == MAX_BURST_C);
`endif

    // Grants are masked while reset is held so every output reads 0 during reset.
    if (!reset) begin
      if (core_req && (!io_req || !io_wins)) begin
        core_gnt = 1'b1;
      end else if (io_req) begin
        io_gnt = 1'b1;
      end
    end

    if (core_gnt) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = core_we;
      state_d   = CORE;
      rd_pend_d = !core_we;
    end else if (io_gnt) begin
      mem_addr  = io_addr;
      mem_wdata = io_wdata;
      mem_we    = io_we;
      state_d   = IO;
      rd_pend_d = !io_we;
    end

    if (!io_req || io_gnt) begin
      burst_cnt_d = '0;
    end else if (core_gnt && (burst_cnt_q != MAX_BURST_C)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  always_comb begin
    core_rvalid  = rd_pend_q && (state_q == CORE);
    io_rvalid    = rd_pend_q && (state_q == IO);
    core_rdata_d = core_rvalid ? mem_rdata : core_rdata_q;
    io_rdata_d   = io_rvalid ? mem_rdata : io_rdata_q;
    core_rdata   = core_rdata_d;
    io_rdata     = io_rdata_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
      core_rdata_q <= '0;
      io_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= rd_pend_d;
      core_rdata_q <= core_rdata_d;
      io_rdata_q   <= io_rdata_d;
    end
  end

endmodule
